// File: rtl/avmm_cfg_responder_pkg.sv
// Shared types, bus widths and the byte-lane merge helper for the
// configuration-bus responder.
package avmm_cfg_pkg;

    // Transfer sequencing: wait for a strobe, insert wait states, acknowledge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } cfg_rsp_state_e;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Returned for any read that does not hit an implemented register.
    localparam logic [DATA_W-1:0] BAD_READ_DATA = 32'hDEAD_BEEF;

    // Replace only the byte lanes whose enable bit is set; the rest keep the old value.
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] oldWord,
        input logic [DATA_W-1:0] newWord,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = oldWord;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = newWord[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/avmm_cfg_responder_if.sv
// Avalon-MM configuration bus between a config master and the responder.
interface avmm_cfg_if;
    import avmm_cfg_pkg::*;

    logic [ADDR_W-1:0] avmm_address;
    logic [DATA_W-1:0] avmm_writedata;
    logic [BE_W-1:0]   avmm_byteenable;
    logic              avmm_write;
    logic              avmm_read;
    logic              avmm_waitrequest;
    logic [DATA_W-1:0] avmm_readdata;

    modport master (
        output avmm_address, avmm_writedata, avmm_byteenable, avmm_write, avmm_read,
        input  avmm_waitrequest, avmm_readdata
    );

    modport slave (
        input  avmm_address, avmm_writedata, avmm_byteenable, avmm_write, avmm_read,
        output avmm_waitrequest, avmm_readdata
    );

endinterface

// File: rtl/avmm_cfg_responder_regbank.sv
// Register storage for the responder: byte-lane writes, flattened export
// of the whole bank and a single combinational read port.
module avmm_cfg_regbank
    import avmm_cfg_pkg::*;
#(
    parameter int                NUM_REGS  = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_wrEn,
    input  logic [$clog2(NUM_REGS)-1:0] i_wrIdx,
    input  logic [DATA_W-1:0]           i_wrData,
    input  logic [BE_W-1:0]             i_wrBe,
    input  logic [$clog2(NUM_REGS)-1:0] i_rdIdx,
    output logic [NUM_REGS*DATA_W-1:0]  o_regQ,
    output logic [DATA_W-1:0]           o_rdData
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Each register merges the enabled byte lanes when it is the write target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= RESET_VAL;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (i_wrEn && (i_wrIdx == IDX_W'(k))) begin
                    r_regs[k] <= be_merge(r_regs[k], i_wrData, i_wrBe);
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign o_regQ[k*DATA_W +: DATA_W] = r_regs[k];
    end

    // Read mux written as a compare loop so a non-power-of-two bank never indexes past its end.
    always_comb begin
        o_rdData = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (i_rdIdx == IDX_W'(k)) begin
                o_rdData = r_regs[k];
            end
        end
    end

endmodule

// File: rtl/avmm_cfg_responder.sv
// Avalon-MM configuration responder: latches one transfer at a time, paces it
// with a fixed number of wait states, decodes it onto the register bank and
// counts protocol and decode errors.
module avmm_cfg_responder
    import avmm_cfg_pkg::*;
#(
    parameter int                NUM_REGS    = 16,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] RESET_VAL   = 32'h0
) (
    input  logic                        clk,
    input  logic                        rst,
    avmm_cfg_if.slave                   avmm,
    output logic [NUM_REGS*DATA_W-1:0]  reg_q,
    output logic                        wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic [7:0]                  err_count
);
    localparam int         IDX_W     = $clog2(NUM_REGS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    cfg_rsp_state_e    r_state;
    cfg_rsp_state_e    w_nextState;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_isWrite;
    logic [3:0]        r_waitCnt;
    logic [DATA_W-1:0] r_rdHold;
    logic              r_wrPulse;
    logic [IDX_W-1:0]  r_wrIndex;
    logic [7:0]        r_errCount;

    logic              w_reqAny;
    logic              w_strobeHeld;
    logic [14:0]       w_idxFull;
    logic [IDX_W-1:0]  w_idx;
    logic              w_valid;
    logic              w_bankWr;
    logic [DATA_W-1:0] w_bankRd;
    logic [DATA_W-1:0] w_rdWord;
    logic              w_errEvent;

    assign w_reqAny     = avmm.avmm_write | avmm.avmm_read;
    assign w_strobeHeld = r_isWrite ? avmm.avmm_write : avmm.avmm_read;

    assign w_idxFull = r_addr[ADDR_W-1:2];
    assign w_idx     = w_idxFull[IDX_W-1:0];
    assign w_valid   = (r_addr[1:0] == 2'b00) && (w_idxFull < 15'(NUM_REGS));

    assign w_bankWr  = (r_state == ACK) && r_isWrite && w_valid;
    assign w_rdWord  = w_valid ? w_bankRd : BAD_READ_DATA;

    assign w_errEvent = ((r_state == IDLE) && avmm.avmm_write && avmm.avmm_read)
                      || ((r_state == WAIT) && !w_strobeHeld)
                      || ((r_state == ACK) && !w_valid);

    avmm_cfg_regbank #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL)
    ) u_regbank (
        .clk      (clk),
        .rst      (rst),
        .i_wrEn   (w_bankWr),
        .i_wrIdx  (w_idx),
        .i_wrData (r_wdata),
        .i_wrBe   (r_be),
        .i_rdIdx  (w_idx),
        .o_regQ   (reg_q),
        .o_rdData (w_bankRd)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a dropped strobe during wait states abandons the transfer before it can be acknowledged.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_reqAny) begin
                    w_nextState = (WAIT_CYCLES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!w_strobeHeld) begin
                    w_nextState = IDLE;
                end else if (r_waitCnt == 4'd0) begin
                    w_nextState = ACK;
                end
            end
            ACK:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Bus outputs: waitrequest drops only in ACK; a read presents live data in ACK and the held copy otherwise.
    always_comb begin
        avmm.avmm_waitrequest = 1'b1;
        avmm.avmm_readdata    = r_rdHold;
        if (r_state == ACK) begin
            avmm.avmm_waitrequest = 1'b0;
            if (!r_isWrite) begin
                avmm.avmm_readdata = w_rdWord;
            end
        end
    end

    // Request capture, wait-state count, read hold, write notification and the saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_isWrite  <= 1'b0;
            r_waitCnt  <= 4'd0;
            r_rdHold   <= '0;
            r_wrPulse  <= 1'b0;
            r_wrIndex  <= '0;
            r_errCount <= 8'd0;
        end else begin
            if ((r_state == IDLE) && w_reqAny) begin
                r_addr    <= avmm.avmm_address;
                r_wdata   <= avmm.avmm_writedata;
                r_be      <= avmm.avmm_byteenable;
                r_isWrite <= avmm.avmm_write;
                r_waitCnt <= WAIT_LOAD;
            end else if ((r_state == WAIT) && (r_waitCnt != 4'd0)) begin
                r_waitCnt <= r_waitCnt - 4'd1;
            end

            if ((r_state == ACK) && !r_isWrite) begin
                r_rdHold <= w_rdWord;
            end

            r_wrPulse <= w_bankWr;
            if (w_bankWr) begin
                r_wrIndex <= w_idx;
            end

            if (w_errEvent && (r_errCount != 8'hFF)) begin
                r_errCount <= r_errCount + 8'd1;
            end
        end
    end

    assign wr_pulse  = r_wrPulse;
    assign wr_index  = r_wrIndex;
    assign err_count = r_errCount;

endmodule

// File: tb/tb_avmm_cfg_responder.sv
// Self-checking bench for avmm_cfg_responder: directed plan items plus a
// randomized transfer stream, all checked against an array-based model.
module tb_avmm_cfg_responder;

   localparam int NREGS = 16;
   localparam int WAITA = 1;

   logic clk;
   logic rst;

   avmm_cfg_if busA();
   avmm_cfg_if busB();

   logic [NREGS*32-1:0] regQA;
   logic                wrPulseA;
   logic [3:0]          wrIndexA;
   logic [7:0]          errA;

   logic [NREGS*32-1:0] regQB;
   logic                wrPulseB;
   logic [3:0]          wrIndexB;
   logic [7:0]          errB;

   int checkCount;
   int errorCount;

   logic [31:0] modelRegs [NREGS];
   int          modelErr;
   logic [31:0] lastRead;

   avmm_cfg_responder #(
      .NUM_REGS    (NREGS),
      .WAIT_CYCLES (WAITA),
      .RESET_VAL   (32'h0)
   ) dutA (
      .clk       (clk),
      .rst       (rst),
      .avmm      (busA),
      .reg_q     (regQA),
      .wr_pulse  (wrPulseA),
      .wr_index  (wrIndexA),
      .err_count (errA)
   );

   avmm_cfg_responder #(
      .NUM_REGS    (NREGS),
      .WAIT_CYCLES (0),
      .RESET_VAL   (32'h0)
   ) dutB (
      .clk       (clk),
      .rst       (rst),
      .avmm      (busB),
      .reg_q     (regQB),
      .wr_pulse  (wrPulseB),
      .wr_index  (wrIndexB),
      .err_count (errB)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a wait somewhere never completes.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < NREGS; k++) modelRegs[k] = 32'h0;
      modelErr = 0;
      lastRead = 32'h0;
   endtask

   task automatic modelErrInc();
      if (modelErr < 255) modelErr++;
   endtask

   function automatic logic modelValid(input logic [16:0] addr);
      return (addr[1:0] == 2'b00) && (int'(addr[16:2]) < NREGS);
   endfunction

   task automatic checkBank(input string tag);
      for (int k = 0; k < NREGS; k++) begin
         checkOutput($sformatf("%s_reg%0d", tag, k), regQA[32*k +: 32], modelRegs[k]);
      end
   endtask

   // One master transfer on bus A; with abortEarly the strobe is dropped during the wait state.
   task automatic applyStimulus(input logic isWr, input logic isRd, input logic [16:0] addr,
                                input logic [31:0] data, input logic [3:0] be, input logic abortEarly);
      int          cnt;
      logic        acked;
      logic        valid;
      int          idx;
      logic [31:0] merged;
      valid = modelValid(addr);
      idx   = int'(addr[16:2]);
      @(negedge clk);
      busA.avmm_address    = addr;
      busA.avmm_writedata  = data;
      busA.avmm_byteenable = be;
      busA.avmm_write      = isWr;
      busA.avmm_read       = isRd;
      if (abortEarly) begin
         @(negedge clk);
         checkOutput("abort_wait_wreq", {31'b0, busA.avmm_waitrequest}, 32'd1);
         busA.avmm_write = 1'b0;
         busA.avmm_read  = 1'b0;
         if (isWr && isRd) modelErrInc();
         modelErrInc();
         repeat (3) begin
            @(negedge clk);
            checkOutput("abort_wreq", {31'b0, busA.avmm_waitrequest}, 32'd1);
            checkOutput("abort_pulse", {31'b0, wrPulseA}, 32'd0);
         end
         checkOutput("abort_err", {24'b0, errA}, 32'(modelErr));
         checkBank("abort");
         return;
      end
      cnt   = 0;
      acked = 1'b0;
      while (!acked && cnt < 20) begin
         @(negedge clk);
         cnt++;
         if (!busA.avmm_waitrequest) acked = 1'b1;
      end
      if (!acked) begin
         checkOutput("ack_timeout", 32'd0, 32'd1);
         busA.avmm_write = 1'b0;
         busA.avmm_read  = 1'b0;
         return;
      end
      checkOutput("ack_latency", 32'(cnt), 32'(1 + WAITA));
      if (isRd && !isWr) begin
         lastRead = valid ? modelRegs[idx] : 32'hDEAD_BEEF;
         checkOutput("readdata", busA.avmm_readdata, lastRead);
      end
      busA.avmm_write = 1'b0;
      busA.avmm_read  = 1'b0;
      if (isWr && isRd) modelErrInc();
      if (!valid) modelErrInc();
      if (isWr && valid) begin
         merged = modelRegs[idx];
         for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = data[8*b +: 8];
         end
         modelRegs[idx] = merged;
      end
      @(negedge clk);
      checkOutput("wreq_after_ack", {31'b0, busA.avmm_waitrequest}, 32'd1);
      checkOutput("wr_pulse", {31'b0, wrPulseA}, {31'b0, (isWr && valid)});
      if (isWr && valid) checkOutput("wr_index", {28'b0, wrIndexA}, 32'(idx));
      checkOutput("readdata_hold", busA.avmm_readdata, lastRead);
      checkOutput("err_count", {24'b0, errA}, 32'(modelErr));
      checkBank("xfer");
   endtask

   // Top-level sequence: reset, plan items, random stream, back-to-back, mid-transfer reset, saturation.
   initial begin
      int          gap;
      int          cnt;
      logic        acked;
      int          sel;
      int          idxR;
      logic [1:0]  lowR;
      logic [16:0] addrR;

      checkCount = 0;
      errorCount = 0;
      modelReset();
      busA.avmm_address = '0; busA.avmm_writedata = '0; busA.avmm_byteenable = '0;
      busA.avmm_write = 1'b0; busA.avmm_read = 1'b0;
      busB.avmm_address = '0; busB.avmm_writedata = '0; busB.avmm_byteenable = '0;
      busB.avmm_write = 1'b0; busB.avmm_read = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      checkOutput("rst_wreq", {31'b0, busA.avmm_waitrequest}, 32'd1);
      checkOutput("rst_readdata", busA.avmm_readdata, 32'h0);
      checkOutput("rst_pulse", {31'b0, wrPulseA}, 32'd0);
      checkOutput("rst_index", {28'b0, wrIndexA}, 32'd0);
      checkOutput("rst_err", {24'b0, errA}, 32'd0);
      checkBank("rst");

      applyStimulus(1'b0, 1'b1, 17'h00008, 32'h0, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b0, 17'h0000C, 32'hA5A5_1234, 4'b1111, 1'b0);
      checkOutput("plan_reg3_full", regQA[127:96], 32'hA5A5_1234);
      applyStimulus(1'b1, 1'b0, 17'h0000C, 32'hFFFF_FFFF, 4'b0101, 1'b0);
      checkOutput("plan_reg3_part", regQA[127:96], 32'hA5FF_12FF);
      applyStimulus(1'b0, 1'b1, 17'h0000C, 32'h0, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b0, 17'h00040, 32'h1234_5678, 4'hF, 1'b0);
      applyStimulus(1'b0, 1'b1, 17'h00040, 32'h0, 4'hF, 1'b0);
      checkOutput("plan_err2", {24'b0, errA}, 32'd2);
      applyStimulus(1'b1, 1'b0, 17'h00014, 32'hCAFE_F00D, 4'b0000, 1'b0);
      applyStimulus(1'b0, 1'b1, 17'h00002, 32'h0, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b1, 17'h00010, 32'h0BAD_CAFE, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b0, 17'h00018, 32'h7777_7777, 4'hF, 1'b1);

      for (int n = 0; n < 60; n++) begin
         sel  = $urandom_range(0, 19);
         idxR = $urandom_range(0, 15);
         lowR = 2'b00;
         if ($urandom_range(0, 9) == 0) idxR = $urandom_range(16, 127);
         if ($urandom_range(0, 9) == 0) lowR = 2'($urandom_range(1, 3));
         addrR = {15'(idxR), lowR};
         if (sel < 9)       applyStimulus(1'b1, 1'b0, addrR, $urandom, 4'($urandom_range(0, 15)), 1'b0);
         else if (sel < 18) applyStimulus(1'b0, 1'b1, addrR, $urandom, 4'hF, 1'b0);
         else if (sel == 18) applyStimulus(1'b1, 1'b1, addrR, $urandom, 4'($urandom_range(0, 15)), 1'b0);
         else               applyStimulus(1'b1, 1'b0, addrR, $urandom, 4'hF, 1'b1);
      end

      // Back-to-back writes on the zero-wait-state instance with the strobe held throughout.
      @(negedge clk);
      busB.avmm_address = 17'h00000; busB.avmm_writedata = 32'h1111_1111;
      busB.avmm_byteenable = 4'hF; busB.avmm_write = 1'b1;
      cnt = 0; acked = 1'b0;
      while (!acked && cnt < 10) begin
         @(negedge clk);
         cnt++;
         if (!busB.avmm_waitrequest) acked = 1'b1;
      end
      checkOutput("b2b_first_ack", 32'(cnt), 32'd1);
      busB.avmm_address = 17'h00004; busB.avmm_writedata = 32'h2222_2222;
      gap = 0; acked = 1'b0;
      while (!acked && gap < 10) begin
         @(negedge clk);
         gap++;
         if (gap == 1) begin
            checkOutput("b2b_pulse0", {31'b0, wrPulseB}, 32'd1);
            checkOutput("b2b_index0", {28'b0, wrIndexB}, 32'd0);
         end
         if (!busB.avmm_waitrequest) acked = 1'b1;
      end
      checkOutput("b2b_ack_gap", 32'(gap), 32'd2);
      busB.avmm_write = 1'b0;
      @(negedge clk);
      checkOutput("b2b_pulse1", {31'b0, wrPulseB}, 32'd1);
      checkOutput("b2b_index1", {28'b0, wrIndexB}, 32'd1);
      checkOutput("b2b_reg0", regQB[31:0], 32'h1111_1111);
      checkOutput("b2b_reg1", regQB[63:32], 32'h2222_2222);
      checkOutput("b2b_err", {24'b0, errB}, 32'd0);

      // Reset lands while a write to reg 2 is in its wait state.
      @(negedge clk);
      busA.avmm_address = 17'h00008; busA.avmm_writedata = 32'h1234_5678;
      busA.avmm_byteenable = 4'hF; busA.avmm_write = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      busA.avmm_write = 1'b0;
      modelReset();
      @(negedge clk);
      checkOutput("midrst_wreq", {31'b0, busA.avmm_waitrequest}, 32'd1);
      checkOutput("midrst_pulse", {31'b0, wrPulseA}, 32'd0);
      checkOutput("midrst_reg2", regQA[95:64], 32'h0);
      checkOutput("midrst_err", {24'b0, errA}, 32'd0);
      checkOutput("midrst_readdata", busA.avmm_readdata, 32'h0);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("postrst_pulse", {31'b0, wrPulseA}, 32'd0);
      end
      checkBank("postrst");
      applyStimulus(1'b1, 1'b0, 17'h00008, 32'h8765_4321, 4'hF, 1'b0);
      checkOutput("postrst_reg2", regQA[95:64], 32'h8765_4321);

      // Drive the error counter past its ceiling with out-of-range reads.
      for (int n = 0; n < 260; n++) begin
         applyStimulus(1'b0, 1'b1, 17'h1FFFC, 32'h0, 4'hF, 1'b0);
      end
      checkOutput("err_saturated", {24'b0, errA}, 32'd255);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
